// File: rtl/router_source.sv
// Transmit side of the router port: turns a frame command plus client header/payload
// words into destination word, tagged header words, length word and payload on D.
module router_source (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_DEST,
  input  logic [3:0]  CMD_NHDR,
  input  logic [31:0] CMD_LEN,
  input  logic [63:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [63:0] D,
  output logic        D_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEST = 3'd1,
    S_HDR  = 3'd2,
    S_LENW = 3'd3,
    S_PAY  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  dest, dest_nx;
  logic [3:0]  hdr_cnt, hdr_cnt_nx;
  logic [31:0] pay_cnt, pay_cnt_nx;
  logic [63:0] d_nx;
  logic        d_valid_nx, done_nx, err_nx;

  // Handshake readiness depends on the state alone, never on the client's valid.
  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign IN_READY  = (state == S_HDR) || (state == S_PAY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      hdr_cnt <= 4'd0;
      pay_cnt <= 32'd0;
      D       <= 64'd0;
      D_VALID <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nx;
      hdr_cnt <= hdr_cnt_nx;
      pay_cnt <= pay_cnt_nx;
      D       <= d_nx;
      D_VALID <= d_valid_nx;
      DONE    <= done_nx;
      ERR     <= err_nx;
    end
  end

  always_ff @(posedge CLK) begin
    dest <= dest_nx;
  end

  always_comb begin
    state_nx   = state;
    dest_nx    = dest;
    hdr_cnt_nx = hdr_cnt;
    pay_cnt_nx = pay_cnt;
    d_nx       = D;
    d_valid_nx = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_VALID) begin
          dest_nx    = CMD_DEST;
          hdr_cnt_nx = CMD_NHDR;
          pay_cnt_nx = CMD_LEN;
          if (CMD_LEN == 32'd0) err_nx = 1'b1;
          else                  state_nx = S_DEST;
        end
      end
      S_DEST: begin
        d_nx       = {56'h0, dest};
        d_valid_nx = 1'b1;
        state_nx   = (hdr_cnt != 4'd0) ? S_HDR : S_LENW;
      end
      S_HDR: begin
        if (IN_VALID) begin
          d_nx       = {8'h01, IN_DATA[55:0]};
          d_valid_nx = 1'b1;
          hdr_cnt_nx = hdr_cnt - 4'd1;
          if (hdr_cnt == 4'd1) state_nx = S_LENW;
        end
      end
      S_LENW: begin
        // The payload counter still holds the untouched length here.
        d_nx       = {32'h0, pay_cnt};
        d_valid_nx = 1'b1;
        state_nx   = S_PAY;
      end
      S_PAY: begin
        if (IN_VALID) begin
          d_nx       = IN_DATA;
          d_valid_nx = 1'b1;
          pay_cnt_nx = pay_cnt - 32'd1;
          if (pay_cnt == 32'd1) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_source.sv
// Bench for router_source: directed and random frames checked against a frame-level
// model (expected word list, handshake-relative timing) built in the bench.
module tb_router_source;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID, CMD_READY;
  logic [7:0]  CMD_DEST;
  logic [3:0]  CMD_NHDR;
  logic [31:0] CMD_LEN;
  logic [63:0] IN_DATA;
  logic        IN_VALID, IN_READY;
  logic [63:0] D;
  logic        D_VALID, BUSY, DONE, ERR;

  router_source dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DEST(CMD_DEST), .CMD_NHDR(CMD_NHDR), .CMD_LEN(CMD_LEN),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .D_VALID(D_VALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  dest;
    logic [3:0]  nhdr;
    logic [31:0] len;
  } cmd_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  cmd_t        cmds[$];
  logic [63:0] data_q[$];
  int          acc_c[$];
  int          hs_c[$];
  logic [64:0] got_w[$];
  int          got_c[$];
  int          err_c[$];
  int          busy_rdy_bad = 0;
  int          stray_done = 0;
  int          inrdy_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Port monitor: every valid word is logged with its DONE flag and cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (D_VALID) begin
        got_w.push_back({DONE, D});
        got_c.push_back(cyc);
      end else if (DONE) stray_done <= stray_done + 1;
      if (ERR) err_c.push_back(cyc);
      if (BUSY && CMD_READY) busy_rdy_bad <= busy_rdy_bad + 1;
      if (IN_READY) inrdy_cnt <= inrdy_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic add_cmd(input logic [7:0] dest, input logic [3:0] nhdr, input logic [31:0] len);
    cmd_t c;
    c.dest = dest; c.nhdr = nhdr; c.len = len;
    cmds.push_back(c);
  endtask

  task automatic drive_cmds();
    foreach (cmds[i]) begin
      CMD_VALID = 1'b1;
      CMD_DEST  = cmds[i].dest;
      CMD_NHDR  = cmds[i].nhdr;
      CMD_LEN   = cmds[i].len;
      for (int t = 0; t < 2000 && !CMD_READY; t++) @(negedge CLK);
      chk("cmd_accept", CMD_READY, 1);
      if (!CMD_READY) begin
        CMD_VALID = 1'b0;
        return;
      end
      acc_c.push_back(cyc);
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
  endtask

  task automatic drive_data(input int gap);
    bit ph = 1'b1;
    for (int b = 0; b < 5000 && data_q.size() > 0; b++) begin
      IN_DATA  = data_q[0];
      IN_VALID = (gap == 0) ? 1'b1 : (gap == 1) ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      if (IN_VALID && IN_READY) begin
        hs_c.push_back(cyc);
        void'(data_q.pop_front());
      end
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk("data_drained", data_q.size(), 0);
  endtask

  task automatic run_batch(input int gap);
    logic [64:0] ew[$];
    int          kind[$];
    int          cidx[$];
    logic [63:0] w;
    int wb, hb, ab, eb, rb, bb, sb, n_err, ndata, j, m;
    wb = got_w.size(); hb = hs_c.size(); ab = acc_c.size(); eb = err_c.size();
    rb = inrdy_cnt; bb = busy_rdy_bad; sb = stray_done;
    n_err = 0; ndata = 0;
    foreach (cmds[i]) begin
      if (cmds[i].len == 0) begin
        n_err++;
        continue;
      end
      ew.push_back({1'b0, 56'h0, cmds[i].dest}); kind.push_back(0); cidx.push_back(i);
      for (int h = 0; h < cmds[i].nhdr; h++) begin
        w = {$urandom, $urandom};
        data_q.push_back(w);
        ew.push_back({1'b0, 8'h01, w[55:0]}); kind.push_back(1); cidx.push_back(i);
      end
      ew.push_back({1'b0, 32'h0, cmds[i].len}); kind.push_back(2); cidx.push_back(i);
      for (int p = 0; p < cmds[i].len; p++) begin
        w = {$urandom, $urandom};
        data_q.push_back(w);
        ew.push_back({(p == cmds[i].len - 1), w}); kind.push_back(1); cidx.push_back(i);
      end
      ndata += cmds[i].nhdr + cmds[i].len;
    end

    fork
      drive_cmds();
      drive_data(gap);
    join
    repeat (4) @(negedge CLK);

    chk("acc_count", acc_c.size() - ab, cmds.size());
    chk("word_count", got_w.size() - wb, ew.size());
    j = 0;
    for (int i = 0; i < ew.size() && wb + i < got_w.size(); i++) begin
      chk($sformatf("word%0d", i), got_w[wb + i], ew[i]);
      if (kind[i] == 0 && ab + cidx[i] < acc_c.size())
        chk("dest_latency", got_c[wb + i], acc_c[ab + cidx[i]] + 2);
      if (kind[i] == 1) begin
        if (hb + j < hs_c.size()) chk("data_latency", got_c[wb + i], hs_c[hb + j] + 1);
        j++;
      end
      if (kind[i] == 2) chk("lenw_follows", got_c[wb + i], got_c[wb + i - 1] + 1);
      if (kind[i] == 0 && i > 0 && cmds[cidx[i] - 1].len != 0)
        chk("frame_gap", got_c[wb + i], got_c[wb + i - 1] + 2);
      if (gap == 0 && kind[i] != 0) chk("contiguous", got_c[wb + i], got_c[wb + i - 1] + 1);
    end

    chk("err_count", err_c.size() - eb, n_err);
    m = 0;
    foreach (cmds[i]) begin
      if (cmds[i].len == 0 && ab + i < acc_c.size()) begin
        if (eb + m < err_c.size()) chk("err_timing", err_c[eb + m], acc_c[ab + i] + 1);
        m++;
        if (i + 1 < cmds.size() && ab + i + 1 < acc_c.size())
          chk("len0_stays_idle", acc_c[ab + i + 1], acc_c[ab + i] + 1);
      end
    end
    if (gap == 0) chk("in_ready_cycles", inrdy_cnt - rb, ndata);
    chk("cmd_ready_while_busy", busy_rdy_bad - bb, 0);
    chk("done_without_word", stray_done - sb, 0);
    cmds.delete();
    data_q.delete();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_d"}, D, 0);
    chk({pfx, "_dvalid"}, D_VALID, 0);
    chk({pfx, "_done"}, DONE, 0);
    chk({pfx, "_err"}, ERR, 0);
    chk({pfx, "_busy"}, BUSY, 0);
    chk({pfx, "_cmd_ready"}, CMD_READY, 1);
    chk({pfx, "_in_ready"}, IN_READY, 0);
  endtask

  initial begin
    int n;
    CMD_VALID = 1'b0; CMD_DEST = '0; CMD_NHDR = '0; CMD_LEN = '0;
    IN_DATA = '0; IN_VALID = 1'b0;
    #1 RST = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    add_cmd(8'h05, 4'd2, 32'd3);
    run_batch(0);
    add_cmd(8'h21, 4'd0, 32'd1);
    run_batch(0);
    add_cmd(8'h7a, 4'd1, 32'd0);
    add_cmd(8'h12, 4'd3, 32'd2);
    run_batch(0);
    add_cmd(8'h44, 4'd2, 32'd4);
    run_batch(1);
    add_cmd(8'h0c, 4'd1, 32'd2);
    add_cmd(8'h0d, 4'd2, 32'd3);
    run_batch(0);

    // Truncate a frame with an asynchronous reset while two payload words remain.
    CMD_VALID = 1'b1; CMD_DEST = 8'h33; CMD_NHDR = 4'd0; CMD_LEN = 32'd4;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    IN_VALID = 1'b1;
    n = 0;
    for (int t = 0; t < 50 && n < 2; t++) begin
      IN_DATA = {$urandom, $urandom};
      if (IN_READY) n++;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk("pre_reset_dvalid", D_VALID, 1);
    chk("pre_reset_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    add_cmd(8'h5e, 4'd2, 32'd3);
    run_batch(0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++)
        add_cmd(8'($urandom), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 6) == 0) ? 32'd0 : 32'($urandom_range(1, 6)));
      run_batch(r % 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
